// File: rtl/reg_serial_tx_pkg.sv
// Shared types and helpers for the parallel-in serial-out register transmitter.
package reg_serial_tx_pkg;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

    // Bit-counter width; only needs to reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/reg_serial_tx_slice.sv
// One bit of the transmit shift register: load, shift-from-neighbour or hold.
module tx_shift_slice (
    input  logic clk,
    input  logic clr,
    input  logic ld,
    input  logic sh,
    input  logic ld_bit,
    input  logic sh_bit,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clr)     q <= 1'b0;
        else if (ld) q <= ld_bit;
        else if (sh) q <= sh_bit;
    end

endmodule

// File: rtl/reg_serial_tx.sv
// Parallel-in, serial-out transmitter with valid/ready load and back-to-back framing.
module reg_serial_tx
    import reg_serial_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             sh_en,
    output logic             sl_out,
    output logic             sl_frame,
    output logic             sl_last,
    output logic             tx_done
);

    localparam int CW = cnt_width(WIDTH);

    tx_state_e        state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sh_in;
    logic             load, shift, fin;

    assign fin   = (state == TX_SHIFT) && (cnt == CW'(WIDTH - 1)) && sh_en;
    assign load  = ld_valid && ld_ready;
    assign shift = (state == TX_SHIFT) && sh_en && !(cnt == CW'(WIDTH - 1));

    // Neighbour wiring moves bits toward the output end; the far end fills with zero.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        if (LSB_FIRST != 0) begin : g_lsb
            if (i == WIDTH - 1) begin : g_end
                assign sh_in[i] = 1'b0;
            end else begin : g_mid
                assign sh_in[i] = sreg[i+1];
            end
        end else begin : g_msb
            if (i == 0) begin : g_end
                assign sh_in[i] = 1'b0;
            end else begin : g_mid
                assign sh_in[i] = sreg[i-1];
            end
        end

        tx_shift_slice u_slice (
            .clk    (clk),
            .clr    (clr),
            .ld     (load),
            .sh     (shift),
            .ld_bit (ld_data[i]),
            .sh_bit (sh_in[i]),
            .q      (sreg[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_done <= fin;
            if (load)       cnt <= '0;
            else if (shift) cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            TX_IDLE:  if (load) state_nxt = TX_SHIFT;
            TX_SHIFT: if (fin)  state_nxt = ld_valid ? TX_SHIFT : TX_IDLE;
            default:            state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        sl_frame = (state == TX_SHIFT);
        sl_last  = sl_frame && (cnt == CW'(WIDTH - 1));
        sl_out   = 1'b0;
        if (sl_frame) sl_out = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];
        // Ready opens on the consumed last bit so the next word follows with no gap.
        ld_ready = (state == TX_IDLE) || fin;
    end

endmodule

// File: doc/reg_serial_tx.md
# reg_serial_tx

Parallel-in, serial-out register transmitter. Accepts a WIDTH-bit word over a valid/ready load port and shifts it out one bit per enabled cycle on `sl_out`. It is the sending end of the load-strobe serial bit-slice register chain: a receiving chain samples `sl_out` on cycles where `sl_frame` and `sh_en` are both high. Sits between the datapath that produces a word and any serial register or link that consumes it.

## Interface
- `WIDTH`, default 8: word width in bits; legal range ≥ 2.
- `LSB_FIRST`, default 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.

- `clk`  in  1  rising-edge clock; the only clock.
- `clr`  in  1  synchronous, active-high reset; sampled on the `clk` rising edge.
- `ld_valid`  in  1  `ld_data` is presented for loading.
- `ld_ready`  out  1  block can accept a word this cycle.
- `ld_data`  in  WIDTH  word to serialize.
- `sh_en`  in  1  consumer advance strobe; 0 holds the current bit.
- `sl_out`  out  1  current serial bit.
- `sl_frame`  out  1  `sl_out` carries a valid bit of the current word.
- `sl_last`  out  1  `sl_out` is the final bit of the word.
- `tx_done`  out  1  one-cycle pulse after the final bit is consumed.

## Operation
- FSM states: IDLE and SHIFT.
- IDLE:
  - `ld_ready`=1, `sl_frame`=0, `sl_out`=0.
  - On `ld_valid`&&`ld_ready`: capture `ld_data` into the shift register, set bit counter `cnt`=0, go to SHIFT.
- SHIFT:
  - `sl_frame`=1.
  - `sl_out` = shift register bit 0 when LSB_FIRST=1, bit WIDTH-1 otherwise.
  - `sl_last` = (`cnt`==WIDTH-1).
- SHIFT with `sh_en`=1 and not last: shift one position (zero fill), `cnt`+1.
- SHIFT with `sh_en`=0: everything holds. No bit is ever skipped or repeated.
- SHIFT, last bit, `sh_en`=1:
  - Pulse `tx_done` next cycle.
  - If `ld_valid`=1: load the new word and stay in SHIFT with `cnt`=0, giving back-to-back frames with no gap.
  - Otherwise: go to IDLE.
- `ld_ready` = IDLE || (SHIFT && `sl_last` && `sh_en`). It is combinational from state, `cnt` and `sh_en`; it does not depend on `ld_valid`.
- `ld_valid` while `ld_ready`=0 is ignored; no word is captured.
- `cnt` is $clog2(WIDTH) bits wide and never exceeds WIDTH-1; there is no wrap-around beyond it.

## Timing
- Reset: a `clr` edge forces IDLE, shift register=0, `cnt`=0.
  - After that edge: `sl_out`=0, `sl_frame`=0, `sl_last`=0, `tx_done`=0, `ld_ready`=1.
  - `clr` has priority over load and shift in the same cycle.
  - `clr` mid-frame aborts the frame: no `tx_done` and no partial bits afterward.
- Load latency: word accepted at edge N → first bit on `sl_out` with `sl_frame`=1 during cycle N+1.
- With `sh_en` held at 1, a frame occupies exactly WIDTH cycles. `tx_done` is high in the cycle after the `sl_last` cycle, which is also the first bit of a back-to-back word if one was loaded.
- Outputs `sl_out`, `sl_frame`, `sl_last` and `tx_done` are registered or derived only from registered state; there is no combinational path from `ld_*` to them.

## Structure
- Shared package holds:
  - state encoding (`TX_IDLE`, `TX_SHIFT`) as a typedef'd enum;
  - a count-width function of WIDTH.
- One natural sub-module: `tx_shift_slice`, a per-bit cell.
  - 3-way select: load `ld_data[i]`, shift from neighbour, or hold.
  - Feeds a synchronous-clear DFF.
  - Instantiated WIDTH times by generate; the neighbour direction is set by LSB_FIRST.
- FSM, counter and handshake logic live in the top module.

## Test plan
- WIDTH=8, LSB_FIRST=1, load 0xA5, `sh_en`=1 → `sl_out` = 1,0,1,0,0,1,0,1 in cycles 1–8; `sl_last` in cycle 8; `tx_done` in cycle 9; `ld_ready`=1 in cycle 9.
- LSB_FIRST=0, load 0xA5 → `sl_out` = 1,0,1,0,0,1,0,1 MSB first, i.e. bits 7..0.
- Back-to-back: 0xA5, then 0x3C with `ld_valid` held → 16 contiguous `sl_frame` cycles; the 0x3C bits 0,0,1,1,1,1,0,0 start in cycle 9.
- `sh_en` pattern 1,0,0,1,… on 0xF0 → each bit held while `sh_en`=0; exactly 8 consumed bits; `tx_done` after the 8th.
- `ld_valid`=1 with 0xFF in cycle 3 of a 0x00 frame → `ld_ready`=0 and the word is ignored; the 0x00 frame completes unchanged.
- `clr` asserted in cycle 4 of a frame → next cycle `sl_frame`=0, `sl_out`=0, `ld_ready`=1, no `tx_done`; a new load of 0x81 then transmits cleanly.
